// File: rtl/aha_xgcd_apb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aha_xgcd_ctrl_pkg
// Purpose  : Shared constants for the XGCD APB control front-end. Holds the
//            register word offsets, the CTRL/STATUS bit positions, the run FSM
//            state type and a small address helper.
// Ports    : none (package)
// Config   : AHA_XGCD_CTRL_TIMEOUT_EN (consumed by the files importing this)
// Revision : 1.0 - initial release
// ============================================================================
package aha_xgcd_ctrl_pkg;

  // Register word offsets (byte address [11:2])
  localparam logic [9:0] C_REG_CTRL   = 10'h000;
  localparam logic [9:0] C_REG_STATUS = 10'h001;
  localparam logic [9:0] C_REG_CYCLES = 10'h002;
  localparam logic [9:0] C_REG_TMO    = 10'h003;

  // CTRL bit positions
  localparam int C_CTRL_START_BIT  = 0;
  localparam int C_CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions
  localparam int C_STAT_BUSY_BIT = 0;
  localparam int C_STAT_DONE_BIT = 1;
  localparam int C_STAT_TMO_BIT  = 2;

  // Run FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Word index of an APB byte address; the two low bits are never decoded.
  function automatic logic [9:0] reg_word(input logic [11:0] addr);
    return addr[11:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aha_xgcd_apb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aha_xgcd_apb_ctrl_if
// Purpose  : APB3 slave bus bundle for the XGCD control front-end.
// Ports    : PADDR[11:0], PSEL, PENABLE, PWRITE, PWDATA[31:0] (master->slave)
//            PRDATA[31:0], PREADY, PSLVERR                  (slave->master)
// Revision : 1.0 - initial release
// ============================================================================
interface aha_xgcd_apb_ctrl_if;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/aha_xgcd_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : aha_xgcd_run_counter
// Purpose  : Run-length cycle counter. Clears on clr_i, increments by one on
//            every cycle en_i is high, saturates at all-ones and holds
//            otherwise. Optionally compares the post-increment value against a
//            nonzero limit.
// Ports    : clk_i, rst_ni      clock, async active-low reset
//            clr_i, en_i        clear / count enable
//            limit_i, hit_o     timeout limit and match (timeout build only)
//            cnt_next_o         value the counter takes at the coming edge
// Config   : AHA_XGCD_CTRL_TIMEOUT_EN enables the limit comparator
// Revision : 1.0 - initial release
// ============================================================================
module aha_xgcd_run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
`ifdef AHA_XGCD_CTRL_TIMEOUT_EN
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o,
`endif
  output logic [CNT_W-1:0] cnt_next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] w_inc;

  assign w_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = w_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The FSM exits on the same edge the counter reaches the run length, so the
  // comparison and the latched length both use the post-increment value.
  assign cnt_next_o = cnt_d;

`ifdef AHA_XGCD_CTRL_TIMEOUT_EN
  assign hit_o = en_i & ~clr_i & (limit_i != '0) & (cnt_d == limit_i);
`endif

endmodule
`default_nettype wire

// File: rtl/aha_xgcd_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aha_xgcd_apb_ctrl
// Purpose  : APB control/status front-end for one XGCD core. Issues a
//            single-cycle start pulse on a START write, tracks the run until
//            the core reports done (or an optional timeout fires), records
//            the run length and raises a level interrupt.
// Ports    : CLK, RESETn           clock, async active-low reset
//            apb (slave modport)  APB register bus, zero wait states
//            XGCD_START (out)     one-cycle start pulse to the core
//            XGCD_DONE  (in)      core completion, level or pulse
//            XGCD_BUSY  (out)     high while a run is in progress
//            IRQ        (out)     registered interrupt level
// Config   : AHA_XGCD_CTRL_TIMEOUT_EN adds TMO_LIMIT (0x00C) and STATUS.TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module aha_xgcd_apb_ctrl
  import aha_xgcd_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  aha_xgcd_apb_ctrl_if.slave   apb,
  output logic                 XGCD_START,
  input  logic                 XGCD_DONE,
  output logic                 XGCD_BUSY,
  output logic                 IRQ
);

  // --------------------------------------------------------------------------
  // APB decode
  // --------------------------------------------------------------------------
  logic       w_access;
  logic       w_wr;
  logic [9:0] w_word;
  logic       w_sel_ctrl;
  logic       w_sel_stat;
  logic       w_sel_cyc;
  logic       w_sel_tmo;
  logic       w_mapped;

  assign w_access   = apb.PSEL & apb.PENABLE;
  assign w_wr       = w_access & apb.PWRITE;
  assign w_word     = reg_word(apb.PADDR);
  assign w_sel_ctrl = (w_word == C_REG_CTRL);
  assign w_sel_stat = (w_word == C_REG_STATUS);
  assign w_sel_cyc  = (w_word == C_REG_CYCLES);
`ifdef AHA_XGCD_CTRL_TIMEOUT_EN
  assign w_sel_tmo  = (w_word == C_REG_TMO);
`else
  assign w_sel_tmo  = 1'b0;
`endif
  assign w_mapped   = w_sel_ctrl | w_sel_stat | w_sel_cyc | w_sel_tmo;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             start_q, start_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] w_tmo_limit;

  logic             w_busy;
  logic             w_start_req;
  logic             w_start_acc;
  logic             w_start_err;
  logic             w_run_done;
  logic             w_run_tmo;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_busy      = (state_q == ST_RUN);
  assign w_start_req = w_wr & w_sel_ctrl & apb.PWDATA[C_CTRL_START_BIT];
  assign w_start_acc = w_start_req & ~w_busy;
  assign w_start_err = w_start_req & w_busy;

  // --------------------------------------------------------------------------
  // Run counter
  // --------------------------------------------------------------------------
  aha_xgcd_run_counter #(
    .CNT_W (CNT_W)
  ) u_run_counter (
    .clk_i      (CLK),
    .rst_ni     (RESETn),
    .clr_i      (w_start_acc),
    .en_i       (w_busy),
`ifdef AHA_XGCD_CTRL_TIMEOUT_EN
    .limit_i    (w_tmo_limit),
    .hit_o      (w_tmo_hit),
`endif
    .cnt_next_o (w_cnt_next)
  );

`ifdef AHA_XGCD_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_limit_q, tmo_limit_d;

  always_comb begin
    tmo_limit_d = tmo_limit_q;
    if (w_wr && w_sel_tmo) begin
      tmo_limit_d = apb.PWDATA[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tmo_limit_q <= '0;
    end else begin
      tmo_limit_q <= tmo_limit_d;
    end
  end

  assign w_tmo_limit = tmo_limit_q;
`else
  assign w_tmo_limit = '0;
  assign w_tmo_hit   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Run FSM: DONE is checked before the timeout so it wins a same-cycle tie.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    w_run_done = 1'b0;
    w_run_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start_acc) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (XGCD_DONE) begin
          state_d    = ST_IDLE;
          w_run_done = 1'b1;
        end else if (w_tmo_hit) begin
          state_d   = ST_IDLE;
          w_run_tmo = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control/status registers. Hardware sets are applied last so they win over
  // a same-cycle W1C.
  // --------------------------------------------------------------------------
  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    cycles_d = cycles_q;
    start_d  = w_start_acc;
    irq_d    = irq_en_q & (done_q | tmo_q);

    if (w_wr && w_sel_ctrl) begin
      irq_en_d = apb.PWDATA[C_CTRL_IRQ_EN_BIT];
    end
    if (w_wr && w_sel_stat) begin
      if (apb.PWDATA[C_STAT_DONE_BIT]) done_d = 1'b0;
      if (apb.PWDATA[C_STAT_TMO_BIT])  tmo_d  = 1'b0;
    end
    if (w_start_acc) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (w_run_done) begin
      done_d   = 1'b1;
      cycles_d = w_cnt_next;
    end
    if (w_run_tmo) begin
      tmo_d    = 1'b1;
      cycles_d = w_cnt_next;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      cycles_q <= cycles_d;
    end
  end

  // --------------------------------------------------------------------------
  // APB read path and response
  // --------------------------------------------------------------------------
  always_comb begin
    apb.PRDATA = '0;
    if (w_access && !apb.PWRITE) begin
      if (w_sel_ctrl) begin
        apb.PRDATA[C_CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      if (w_sel_stat) begin
        apb.PRDATA[C_STAT_BUSY_BIT] = w_busy;
        apb.PRDATA[C_STAT_DONE_BIT] = done_q;
        apb.PRDATA[C_STAT_TMO_BIT]  = tmo_q;
      end
      if (w_sel_cyc) begin
        apb.PRDATA = 32'(cycles_q);
      end
      if (w_sel_tmo) begin
        apb.PRDATA = 32'(w_tmo_limit);
      end
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_access & (~w_mapped | w_start_err);

  assign XGCD_START = start_q;
  assign XGCD_BUSY  = w_busy;
  assign IRQ        = irq_q;

  // Address bits below word granularity and write-data bits beyond the
  // implemented fields are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};

endmodule
`default_nettype wire
